cdclib_lvlfilt: RTL and testbench

//  Per-bit glitch filter and edge detector that sits downstream of the 4-stage level synchronizer.

---
 rtl/cdclib_pkg.sv | 21 ++
 rtl/cdclib_lvlfilt_if.sv | 26 ++
 rtl/cdclib_lvlfilt_bit.sv | 67 ++++++
 rtl/cdclib_lvlfilt.sv | 56 +++++
 tb/tb_cdclib_lvlfilt.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/cdclib_pkg.sv
// Shared helpers for the cdclib filter blocks: counter sizing and parameter legality.
package cdclib_pkg;

  localparam int FILTER_CYCLES_MIN = 1;
  localparam int FILTER_CYCLES_MAX = 255;

  // Smallest r with 2**r >= v; written as a bounded loop so it folds at elaboration.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit fc_legal(input int fc);
    return (fc >= FILTER_CYCLES_MIN) && (fc <= FILTER_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/cdclib_lvlfilt_if.sv
// Level-filter data bundle: mode select, synchronized levels in, filtered levels and edge pulses out.
interface cdclib_lvlfilt_if #(
  parameter int DWIDTH = 1
);
  logic              filt_en;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic [DWIDTH-1:0] rise_pls;
  logic [DWIDTH-1:0] fall_pls;

  modport master (
    output filt_en,
    output data_in,
    input  data_out,
    input  rise_pls,
    input  fall_pls
  );

  modport slave (
    input  filt_en,
    input  data_in,
    output data_out,
    output rise_pls,
    output fall_pls
  );
endinterface

// File: rtl/cdclib_lvlfilt_bit.sv
// One filtered bit: run-length counter, accepted level register and registered rise/fall pulses.
module cdclib_lvlfilt_bit
  import cdclib_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic filt_en,
  input  logic en_chg,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW      = clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!filt_en) begin
      cnt_d = '0;
      out_d = din;
    end else if (en_chg) begin
      // Re-entering filter mode: restart the run count from the current output.
      cnt_d = '0;
    end else if (din == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      out_d = din;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/cdclib_lvlfilt.sv
// Per-bit glitch filter with edge detect for already-synchronized levels; bits are independent.
module cdclib_lvlfilt
  import cdclib_pkg::*;
#(
  parameter int                DWIDTH        = 1,
  parameter int                FILTER_CYCLES = 4,
  parameter logic [DWIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  cdclib_lvlfilt_if.slave  bus
);

  if (!fc_legal(FILTER_CYCLES)) begin : g_bad_fc
    $error("cdclib_lvlfilt: FILTER_CYCLES=%0d outside 1..255", FILTER_CYCLES);
  end

  logic              filt_en_q, filt_en_d;
  logic              en_chg;
  logic [DWIDTH-1:0] data_out_w;
  logic [DWIDTH-1:0] rise_w;
  logic [DWIDTH-1:0] fall_w;

  // Reset matches the usual filtering mode so a filt_en=1 start is not seen as a mode change.
  always_comb begin
    filt_en_d = bus.filt_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_en_q <= 1'b1;
    else        filt_en_q <= filt_en_d;
  end

  assign en_chg = bus.filt_en ^ filt_en_q;

  for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_bit
    cdclib_lvlfilt_bit #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VAL[gi])
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .filt_en (bus.filt_en),
      .en_chg  (en_chg),
      .din     (bus.data_in[gi]),
      .dout    (data_out_w[gi]),
      .rise    (rise_w[gi]),
      .fall    (fall_w[gi])
    );
  end

  assign bus.data_out = data_out_w;
  assign bus.rise_pls = rise_w;
  assign bus.fall_pls = fall_w;

endmodule

// File: tb/tb_cdclib_lvlfilt.sv
// Directed bench: a 4-bit FILTER_CYCLES=4 instance and a 1-bit FILTER_CYCLES=1 instance resetting to 1.
module tb_cdclib_lvlfilt;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cdclib_lvlfilt_if #(.DWIDTH(4)) m_if ();
  cdclib_lvlfilt_if #(.DWIDTH(1)) o_if ();

  cdclib_lvlfilt #(
    .DWIDTH        (4),
    .FILTER_CYCLES (4),
    .RESET_VAL     (4'b0000)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  cdclib_lvlfilt #(
    .DWIDTH        (1),
    .FILTER_CYCLES (1),
    .RESET_VAL     (1'b1)
  ) u_one (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (o_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s val=%0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [3:0] out, input logic [3:0] r, input logic [3:0] f);
    chk({tag, ".out"},  {4'h0, m_if.data_out}, {4'h0, out});
    chk({tag, ".rise"}, {4'h0, m_if.rise_pls}, {4'h0, r});
    chk({tag, ".fall"}, {4'h0, m_if.fall_pls}, {4'h0, f});
  endtask

  // Advance n clocks expecting data_out to hold at out with no pulses.
  task automatic hold_main(input string tag, input int n, input logic [3:0] out);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_main(tag, out, 4'b0000, 4'b0000);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    m_if.filt_en = 1'b1;
    m_if.data_in = 4'b0000;
    o_if.filt_en = 1'b1;
    o_if.data_in = 1'b1;

    // Reset state, then release with data_in equal to the reset value.
    tick();
    tick();
    chk_main("rst_main", 4'b0000, 4'b0000, 4'b0000);
    chk("rst_one.out",  {7'h0, o_if.data_out}, 8'h01);
    chk("rst_one.rise", {7'h0, o_if.rise_pls}, 8'h00);
    chk("rst_one.fall", {7'h0, o_if.fall_pls}, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rel_one.out",  {7'h0, o_if.data_out}, 8'h01);
    chk("rel_one.rise", {7'h0, o_if.rise_pls}, 8'h00);
    chk("rel_one.fall", {7'h0, o_if.fall_pls}, 8'h00);
    chk_main("rel_main", 4'b0000, 4'b0000, 4'b0000);

    // FILTER_CYCLES=1: accepted on the next clock, pulse lasts one cycle.
    o_if.data_in = 1'b0;
    tick();
    chk("fc1.out",  {7'h0, o_if.data_out}, 8'h00);
    chk("fc1.fall", {7'h0, o_if.fall_pls}, 8'h01);
    tick();
    chk("fc1.fall_end", {7'h0, o_if.fall_pls}, 8'h00);

    // Clean step: four differing samples, change and pulse on the fourth clock.
    m_if.data_in = 4'b0001;
    hold_main("step_wait", 3, 4'b0000);
    tick();
    chk_main("step_hit", 4'b0001, 4'b0001, 4'b0000);
    tick();
    chk_main("step_after", 4'b0001, 4'b0000, 4'b0000);

    // Glitch of 3 cycles is rejected; the next run must count from zero again.
    m_if.data_in = 4'b0000;
    hold_main("glitch", 3, 4'b0001);
    m_if.data_in = 4'b0001;
    hold_main("glitch_back", 1, 4'b0001);
    m_if.data_in = 4'b0000;
    hold_main("glitch_rerun", 3, 4'b0001);
    tick();
    chk_main("glitch_accept", 4'b0000, 4'b0000, 4'b0001);

    // Bypass: one-cycle pass-through with alternating pulses.
    m_if.filt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_if.data_in = 4'b0001;
      tick();
      chk_main("byp_hi", 4'b0001, 4'b0001, 4'b0000);
      m_if.data_in = 4'b0000;
      tick();
      chk_main("byp_lo", 4'b0000, 4'b0000, 4'b0001);
    end

    // filt_en dropped at count 2 clears the counter; re-enabling restarts from scratch.
    m_if.filt_en = 1'b1;
    hold_main("re_en", 2, 4'b0000);
    m_if.data_in = 4'b0001;
    hold_main("mid_cnt", 2, 4'b0000);
    m_if.filt_en = 1'b0;
    m_if.data_in = 4'b0000;
    hold_main("mid_byp", 1, 4'b0000);
    m_if.filt_en = 1'b1;
    m_if.data_in = 4'b0001;
    hold_main("mid_restart", 4, 4'b0000);
    tick();
    chk_main("mid_accept", 4'b0001, 4'b0001, 4'b0000);

    // Asynchronous reset mid-count: outputs go to reset value before the next edge.
    m_if.data_in = 4'b0000;
    hold_main("arst_cnt", 2, 4'b0001);
    o_if.data_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("arst_now", 4'b0000, 4'b0000, 4'b0000);
    chk("arst_one.out", {7'h0, o_if.data_out}, 8'h01);
    tick();
    rst_n = 1'b1;

    // Counters are zero after reset: full four samples needed again.
    m_if.data_in = 4'b0010;
    hold_main("post_rst", 3, 4'b0000);
    tick();
    chk_main("post_rst_hit", 4'b0010, 4'b0010, 4'b0000);

    // Multi-bit: bits 0 and 2 rise while bit 1 falls on the same clock.
    m_if.data_in = 4'b0101;
    hold_main("multi_wait", 3, 4'b0010);
    tick();
    chk_main("multi_hit", 4'b0101, 4'b0101, 4'b0010);
    tick();
    chk_main("multi_after", 4'b0101, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
